fa_response_checker: RTL and testbench

Synthesizable response checker forming the receiving end of the full-adder stimulus path. It observes each applied vector (a, b, ci) together with the DUT outputs (s, co), compares them against a golden model, and accumulates vector and error counts. It latches the first failing vector and reports pass/fail after a fixed number of vectors. It sits beside the full adder, in simulation or on the board, and consumes whatever the stimulus source drives.

---
 rtl/fa_response_checker_if.sv | 31 +++
 rtl/fa_response_checker.sv | 145 ++++++++++++++
 tb/tb_fa_response_checker.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/fa_response_checker_if.sv
// Bundle of stimulus, response and result signals between a full-adder
// stimulus source (master) and fa_response_checker (slave).
interface fa_response_checker_if #(
   parameter int CNT_W = 16
) ();
   logic             start;
   logic             sample;
   logic             a;
   logic             b;
   logic             ci;
   logic             s;
   logic             co;
   logic             busy;
   logic             done;
   logic             pass;
   logic [CNT_W-1:0] vec_cnt;
   logic [CNT_W-1:0] err_cnt;
   logic [4:0]       first_err_vec;
   logic [CNT_W-1:0] first_err_idx;
   logic [7:0]       cov_mask;

   modport master (
      output start, sample, a, b, ci, s, co,
      input  busy, done, pass, vec_cnt, err_cnt, first_err_vec, first_err_idx, cov_mask
   );

   modport slave (
      input  start, sample, a, b, ci, s, co,
      output busy, done, pass, vec_cnt, err_cnt, first_err_vec, first_err_idx, cov_mask
   );
endinterface

// File: rtl/fa_response_checker.sv
// Checks full-adder responses against a golden model over NUM_VECTORS samples.
// Optional input-coverage gating is enabled with FA_CHECKER_COVERAGE_EN.
module fa_response_checker #(
   parameter int NUM_VECTORS = 256,
   parameter int CNT_W       = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   fa_response_checker_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   // Golden full adder: {exp_s, exp_co}
   function automatic logic [1:0] fa_golden(input logic a, input logic b, input logic ci);
      fa_golden = {a ^ b ^ ci, (a & b) | (a & ci) | (b & ci)};
   endfunction

   state_t           r_state, w_next;
   logic [CNT_W-1:0] r_vec, w_vec;
   logic [CNT_W-1:0] r_err, w_err;
   logic [CNT_W-1:0] r_fei, w_fei;
   logic [4:0]       r_fev, w_fev;
   logic             r_seen, w_seen;
   logic [7:0]       r_cov, w_cov;
   logic             r_busy, r_done, r_pass;
   logic             w_mis, w_cov_ok, w_pass;

   assign w_mis = ({bus.s, bus.co} != fa_golden(bus.a, bus.b, bus.ci));

   // Next-state and datapath updates
   always_comb begin
      w_next = r_state;
      w_vec  = r_vec;
      w_err  = r_err;
      w_fei  = r_fei;
      w_fev  = r_fev;
      w_seen = r_seen;
      w_cov  = r_cov;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               w_next = ST_RUN;
               w_vec  = '0;
               w_err  = '0;
               w_fei  = '0;
               w_fev  = 5'd0;
               w_seen = 1'b0;
               w_cov  = 8'h00;
            end else begin
               w_next = r_state;
            end
         end
         ST_RUN: begin
            if (bus.sample) begin
               w_vec = r_vec + {{(CNT_W-1){1'b0}}, 1'b1};
               if (w_mis) begin
                  if (r_err != CNT_MAX) begin
                     w_err = r_err + {{(CNT_W-1){1'b0}}, 1'b1};
                  end else begin
                     w_err = r_err;
                  end
                  if (!r_seen) begin
                     w_fev  = {bus.a, bus.b, bus.ci, bus.s, bus.co};
                     w_fei  = r_vec;
                     w_seen = 1'b1;
                  end else begin
                     w_seen = r_seen;
                  end
               end else begin
                  w_err = r_err;
               end
`ifdef FA_CHECKER_COVERAGE_EN
               w_cov = r_cov | (8'h01 << {bus.a, bus.b, bus.ci});
`endif
               if (r_vec == LAST_IDX) begin
                  w_next = ST_DONE;
               end else begin
                  w_next = ST_RUN;
               end
            end else begin
               w_next = ST_RUN;
            end
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

`ifdef FA_CHECKER_COVERAGE_EN
   assign w_cov_ok = (w_cov == 8'hFF);
`else
   assign w_cov_ok = 1'b1;
`endif
   assign w_pass = (w_next == ST_DONE) && (w_err == '0) && w_cov_ok;

   // State, result and status registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_vec   <= '0;
         r_err   <= '0;
         r_fei   <= '0;
         r_fev   <= 5'd0;
         r_seen  <= 1'b0;
         r_cov   <= 8'h00;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_vec   <= w_vec;
         r_err   <= w_err;
         r_fei   <= w_fei;
         r_fev   <= w_fev;
         r_seen  <= w_seen;
         r_cov   <= w_cov;
         r_busy  <= (w_next == ST_RUN);
         r_done  <= (w_next == ST_DONE);
         r_pass  <= w_pass;
      end
   end

   assign bus.busy          = r_busy;
   assign bus.done          = r_done;
   assign bus.pass          = r_pass;
   assign bus.vec_cnt       = r_vec;
   assign bus.err_cnt       = r_err;
   assign bus.first_err_vec = r_fev;
   assign bus.first_err_idx = r_fei;
`ifdef FA_CHECKER_COVERAGE_EN
   assign bus.cov_mask      = r_cov;
`else
   assign bus.cov_mask      = 8'h00;
`endif

endmodule

// File: tb/tb_fa_response_checker.sv
// Directed bench for fa_response_checker: three instances with different
// parameters share one stimulus bus; each scenario resets or restarts first.
module tb_fa_response_checker;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic t_start = 1'b0, t_sample = 1'b0;
   logic t_a = 1'b0, t_b = 1'b0, t_ci = 1'b0, t_s = 1'b0, t_co = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   fa_response_checker_if #(.CNT_W(16)) if8 ();
   fa_response_checker_if #(.CNT_W(16)) if4 ();
   fa_response_checker_if #(.CNT_W(2))  if3 ();

   assign {if8.start, if8.sample, if8.a, if8.b, if8.ci, if8.s, if8.co} = {t_start, t_sample, t_a, t_b, t_ci, t_s, t_co};
   assign {if4.start, if4.sample, if4.a, if4.b, if4.ci, if4.s, if4.co} = {t_start, t_sample, t_a, t_b, t_ci, t_s, t_co};
   assign {if3.start, if3.sample, if3.a, if3.b, if3.ci, if3.s, if3.co} = {t_start, t_sample, t_a, t_b, t_ci, t_s, t_co};

   fa_response_checker #(.NUM_VECTORS(8), .CNT_W(16)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8));
   fa_response_checker #(.NUM_VECTORS(4), .CNT_W(16)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4));
   fa_response_checker #(.NUM_VECTORS(3), .CNT_W(2))  u3 (.clk(clk), .rst_n(rst_n), .bus(if3));

`ifdef FA_CHECKER_COVERAGE_EN
   localparam bit COV = 1'b1;
`else
   localparam bit COV = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock with the given strobes and vector {a,b,ci,s,co}
   task automatic apply(input logic st, input logic smp, input logic [4:0] v);
      t_start = st;
      t_sample = smp;
      {t_a, t_b, t_ci, t_s, t_co} = v;
      @(posedge clk);
      #1;
      t_start = 1'b0;
      t_sample = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   logic [4:0] good [8];
   initial begin
      good[0] = 5'b00000; good[1] = 5'b00110; good[2] = 5'b01010; good[3] = 5'b01101;
      good[4] = 5'b10010; good[5] = 5'b10101; good[6] = 5'b11001; good[7] = 5'b11111;
   end

   initial begin
      // Reset state and reset mid-run
      do_reset();
      check("rst_busy", {31'd0, if8.busy}, 32'd0);
      check("rst_done", {31'd0, if8.done}, 32'd0);
      check("rst_pass", {31'd0, if8.pass}, 32'd0);
      check("rst_vec", {16'd0, if8.vec_cnt}, 32'd0);
      check("rst_cov", {24'd0, if8.cov_mask}, 32'd0);
      apply(1'b1, 1'b0, 5'd0);
      check("busy_after_start", {31'd0, if8.busy}, 32'd1);
      for (int i = 0; i < 3; i++) apply(1'b0, 1'b1, good[i]);
      check("midrun_vec", {16'd0, if8.vec_cnt}, 32'd3);
      #2 rst_n = 1'b0;
      #1;
      check("async_busy", {31'd0, if8.busy}, 32'd0);
      check("async_vec", {16'd0, if8.vec_cnt}, 32'd0);
      check("async_cov", {24'd0, if8.cov_mask}, 32'd0);
      #1 rst_n = 1'b1;
      apply(1'b0, 1'b1, good[0]);
      check("idle_after_rst", {16'd0, if8.vec_cnt}, 32'd0);

      // Exhaustive correct run, back-to-back
      apply(1'b1, 1'b0, 5'd0);
      for (int i = 0; i < 8; i++) begin
         if (i == 7) check("busy_before_last", {31'd0, if8.done}, 32'd0);
         apply(1'b0, 1'b1, good[i]);
      end
      check("ex_done", {31'd0, if8.done}, 32'd1);
      check("ex_busy", {31'd0, if8.busy}, 32'd0);
      check("ex_vec", {16'd0, if8.vec_cnt}, 32'd8);
      check("ex_err", {16'd0, if8.err_cnt}, 32'd0);
      check("ex_pass", {31'd0, if8.pass}, 32'd1);
      check("ex_cov", {24'd0, if8.cov_mask}, COV ? 32'hFF : 32'h00);
      check("ex_fev", {27'd0, if8.first_err_vec}, 32'd0);

      // First-error latch, restart from DONE
      apply(1'b1, 1'b0, 5'd0);
      check("restart_vec", {16'd0, if8.vec_cnt}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         if (i == 3)      apply(1'b0, 1'b1, 5'b11011);
         else if (i == 5) apply(1'b0, 1'b1, 5'b10111);
         else             apply(1'b0, 1'b1, good[i]);
      end
      check("fe_done", {31'd0, if8.done}, 32'd1);
      check("fe_err", {16'd0, if8.err_cnt}, 32'd2);
      check("fe_idx", {16'd0, if8.first_err_idx}, 32'd3);
      check("fe_vec", {27'd0, if8.first_err_vec}, 32'b11011);
      check("fe_pass", {31'd0, if8.pass}, 32'd0);

      // Coverage gate on the 4-vector instance
      do_reset();
      apply(1'b1, 1'b0, 5'd0);
      for (int i = 0; i < 4; i++) apply(1'b0, 1'b1, good[0]);
      check("cg_done", {31'd0, if4.done}, 32'd1);
      check("cg_err", {16'd0, if4.err_cnt}, 32'd0);
      check("cg_cov", {24'd0, if4.cov_mask}, COV ? 32'h01 : 32'h00);
      check("cg_pass", {31'd0, if4.pass}, COV ? 32'd0 : 32'd1);

      // Ignored events
      do_reset();
      apply(1'b0, 1'b1, good[1]);
      apply(1'b0, 1'b1, 5'b11111);
      check("ign_idle_vec", {16'd0, if8.vec_cnt}, 32'd0);
      check("ign_idle_busy", {31'd0, if8.busy}, 32'd0);
      apply(1'b1, 1'b1, 5'b00011);
      check("ss_busy", {31'd0, if8.busy}, 32'd1);
      check("ss_vec", {16'd0, if8.vec_cnt}, 32'd0);
      check("ss_err", {16'd0, if8.err_cnt}, 32'd0);
      apply(1'b0, 1'b1, good[0]);
      apply(1'b0, 1'b1, good[1]);
      apply(1'b1, 1'b0, 5'd0);
      check("start_in_run_vec", {16'd0, if8.vec_cnt}, 32'd2);
      check("start_in_run_busy", {31'd0, if8.busy}, 32'd1);
      apply(1'b1, 1'b1, good[2]);
      check("start_smp_in_run", {16'd0, if8.vec_cnt}, 32'd3);
      for (int i = 3; i < 8; i++) apply(1'b0, 1'b1, good[i]);
      apply(1'b0, 1'b1, 5'b11100);
      check("ign_done_vec", {16'd0, if8.vec_cnt}, 32'd8);
      check("ign_done_err", {16'd0, if8.err_cnt}, 32'd0);
      check("ign_done_pass", {31'd0, if8.pass}, 32'd1);

      // Saturation on the CNT_W=2 instance
      do_reset();
      apply(1'b1, 1'b0, 5'd0);
      for (int i = 0; i < 3; i++) apply(1'b0, 1'b1, 5'b00010);
      check("sat_done", {31'd0, if3.done}, 32'd1);
      check("sat_err", {30'd0, if3.err_cnt}, 32'd3);
      check("sat_fev", {27'd0, if3.first_err_vec}, 32'b00010);
      check("sat_fei", {30'd0, if3.first_err_idx}, 32'd0);
      check("sat_pass", {31'd0, if3.pass}, 32'd0);
      apply(1'b1, 1'b0, 5'd0);
      check("sat_clr_err", {30'd0, if3.err_cnt}, 32'd0);
      check("sat_clr_fev", {27'd0, if3.first_err_vec}, 32'd0);
      for (int i = 0; i < 3; i++) apply(1'b0, 1'b1, good[i + 4]);
      check("sat2_done", {31'd0, if3.done}, 32'd1);
      check("sat2_vec", {30'd0, if3.vec_cnt}, 32'd3);
      check("sat2_err", {30'd0, if3.err_cnt}, 32'd0);
      check("sat2_pass", {31'd0, if3.pass}, COV ? 32'd0 : 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
